cp0_exc_ctrl: RTL and testbench

- Exception/ERET sequencer between the writeback stage and the CP0 register block.
- Picks one exception from the raw per-instruction request vector and drives the one-hot ex vector, EPC, branch-delay flag and commit strobe into CP0.
- Then flushes the pipeline for a fixed number of cycles and hands a redirect PC (exception vector or EPC) to fetch using a valid/ready handshake.

---
 rtl/cp0_exc_ctrl_if.sv | 37 +++
 rtl/cp0_exc_ctrl.sv | 150 +++++++++++++++
 tb/tb_cp0_exc_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/cp0_exc_ctrl_if.sv
// WB-stage request, CP0 commit and fetch-redirect signals of the exception sequencer.
// The master modport is the controller side; slave is the surrounding pipeline.
interface cp0_exc_ctrl_if;
  localparam int unsigned EX_W  = 6;
  localparam int unsigned PC_W  = 32;
  localparam int unsigned CNT_W = 16;

  logic              wb_valid;
  logic [EX_W-1:0]   wb_ex_req;
  logic [PC_W-1:0]   wb_pc;
  logic              wb_is_bd;
  logic              wb_eret;
  logic [PC_W-1:0]   cp0_epc;
  logic [EX_W-1:0]   cp0_ex;
  logic [PC_W-1:0]   cp0_epc_in;
  logic              cp0_is_bd;
  logic              cp0_valid;
  logic              cp0_eret;
  logic              flush;
  logic              wb_stall;
  logic              redirect_valid;
  logic [PC_W-1:0]   redirect_pc;
  logic              redirect_ready;
  logic [CNT_W-1:0]  exc_count;

  modport master (
    input  wb_valid, wb_ex_req, wb_pc, wb_is_bd, wb_eret, cp0_epc, redirect_ready,
    output cp0_ex, cp0_epc_in, cp0_is_bd, cp0_valid, cp0_eret, flush, wb_stall,
           redirect_valid, redirect_pc, exc_count
  );

  modport slave (
    output wb_valid, wb_ex_req, wb_pc, wb_is_bd, wb_eret, cp0_epc, redirect_ready,
    input  cp0_ex, cp0_epc_in, cp0_is_bd, cp0_valid, cp0_eret, flush, wb_stall,
           redirect_valid, redirect_pc, exc_count
  );
endinterface

// File: rtl/cp0_exc_ctrl.sv
// Exception/ERET sequencer: selects one exception, commits it to CP0, flushes the
// pipeline for a fixed time and hands the redirect PC to fetch with valid/ready.
module cp0_exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input logic            clock,
  input logic            resetn,
  cp0_exc_ctrl_if.master bus
);
  localparam int unsigned EX_W  = 6;
  localparam int unsigned PC_W  = 32;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned FC_W  = 4;

  typedef enum logic [1:0] {IDLE, COMMIT, FLUSH, REDIRECT} state_t;

  state_t            state, state_d;
  logic [EX_W-1:0]   ex_q, ex_d;
  logic [PC_W-1:0]   epc_in_q, epc_in_d;
  logic              is_bd_q, is_bd_d;
  logic              valid_q, valid_d;
  logic              eret_q, eret_d;
  logic              flush_q, flush_d;
  logic              stall_q, stall_d;
  logic              rv_q, rv_d;
  logic [PC_W-1:0]   rpc_q, rpc_d;
  logic [PC_W-1:0]   target_q, target_d;
  logic [FC_W-1:0]   fcnt_q, fcnt_d;
  logic [CNT_W-1:0]  exc_count_q, exc_count_d;

  // Fixed priority: AdEL > RI > Sys > Bp > Ov > AdES
  function automatic logic [EX_W-1:0] pick(input logic [EX_W-1:0] req);
    if (req[0])      return EX_W'(6'b000001);
    else if (req[4]) return EX_W'(6'b010000);
    else if (req[2]) return EX_W'(6'b000100);
    else if (req[3]) return EX_W'(6'b001000);
    else if (req[5]) return EX_W'(6'b100000);
    else if (req[1]) return EX_W'(6'b000010);
    else             return '0;
  endfunction

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_d;
  end

  always_comb begin
    state_d     = state;
    ex_d        = '0;
    eret_d      = 1'b0;
    valid_d     = 1'b0;
    flush_d     = 1'b0;
    rv_d        = 1'b0;
    rpc_d       = '0;
    epc_in_d    = epc_in_q;
    is_bd_d     = is_bd_q;
    target_d    = target_q;
    fcnt_d      = fcnt_q;
    exc_count_d = exc_count_q;
    unique case (state)
      IDLE: begin
        if (bus.wb_valid && (|bus.wb_ex_req)) begin
          ex_d     = pick(bus.wb_ex_req);
          valid_d  = 1'b1;
          flush_d  = 1'b1;
          epc_in_d = bus.wb_is_bd ? (bus.wb_pc - 32'd4) : bus.wb_pc;
          is_bd_d  = bus.wb_is_bd;
          target_d = EXC_VECTOR;
          state_d  = COMMIT;
        end else if (bus.wb_valid && bus.wb_eret) begin
          eret_d   = 1'b1;
          valid_d  = 1'b1;
          flush_d  = 1'b1;
          target_d = bus.cp0_epc;
          state_d  = COMMIT;
        end
      end
      COMMIT: begin
        flush_d = 1'b1;
        fcnt_d  = FC_W'(FLUSH_CYCLES - 1);
        // ex_q is non-zero only when the commit is an exception rather than ERET
        if ((ex_q != '0) && (exc_count_q != 16'hFFFF))
          exc_count_d = exc_count_q + 16'd1;
        state_d = FLUSH;
      end
      FLUSH: begin
        if (fcnt_q == '0) begin
          rv_d    = 1'b1;
          rpc_d   = target_q;
          state_d = REDIRECT;
        end else begin
          flush_d = 1'b1;
          fcnt_d  = fcnt_q - FC_W'(1);
        end
      end
      REDIRECT: begin
        if (bus.redirect_ready) begin
          state_d = IDLE;
        end else begin
          rv_d  = 1'b1;
          rpc_d = target_q;
        end
      end
      default: state_d = IDLE;
    endcase
    stall_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ex_q        <= '0;
      epc_in_q    <= '0;
      is_bd_q     <= 1'b0;
      valid_q     <= 1'b0;
      eret_q      <= 1'b0;
      flush_q     <= 1'b0;
      stall_q     <= 1'b0;
      rv_q        <= 1'b0;
      rpc_q       <= '0;
      target_q    <= '0;
      fcnt_q      <= '0;
      exc_count_q <= '0;
    end else begin
      ex_q        <= ex_d;
      epc_in_q    <= epc_in_d;
      is_bd_q     <= is_bd_d;
      valid_q     <= valid_d;
      eret_q      <= eret_d;
      flush_q     <= flush_d;
      stall_q     <= stall_d;
      rv_q        <= rv_d;
      rpc_q       <= rpc_d;
      target_q    <= target_d;
      fcnt_q      <= fcnt_d;
      exc_count_q <= exc_count_d;
    end
  end

  assign bus.cp0_ex         = ex_q;
  assign bus.cp0_epc_in     = epc_in_q;
  assign bus.cp0_is_bd      = is_bd_q;
  assign bus.cp0_valid      = valid_q;
  assign bus.cp0_eret       = eret_q;
  assign bus.flush          = flush_q;
  assign bus.wb_stall       = stall_q;
  assign bus.redirect_valid = rv_q;
  assign bus.redirect_pc    = rpc_q;
  assign bus.exc_count      = exc_count_q;
endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Bench for cp0_exc_ctrl: directed scenarios plus random transactions checked
// against a cycle-schedule reference model of the exception/ERET sequence.
module tb_cp0_exc_ctrl;
  localparam logic [31:0] EXC_VEC = 32'hBFC00380;
  localparam int unsigned FC      = 2;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [15:0] m_count = '0;

  always #5 clock = ~clock;

  cp0_exc_ctrl_if bus ();

  cp0_exc_ctrl #(.EXC_VECTOR(EXC_VEC), .FLUSH_CYCLES(FC)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus.master)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wb_idle();
    bus.wb_valid  = 1'b0;
    bus.wb_ex_req = '0;
    bus.wb_eret   = 1'b0;
    bus.wb_is_bd  = 1'b0;
    bus.wb_pc     = '0;
    bus.cp0_epc   = '0;
  endtask

  task automatic wb_noise();
    bus.wb_valid  = 1'b1;
    bus.wb_ex_req = 6'($urandom);
    bus.wb_eret   = 1'($urandom);
    bus.wb_is_bd  = 1'($urandom);
    bus.wb_pc     = $urandom;
    bus.cp0_epc   = $urandom;
  endtask

  // Reference: walk the request bits in priority order, first hit wins
  function automatic logic [5:0] m_pick(input logic [5:0] req);
    int order [6] = '{0, 4, 2, 3, 5, 1};
    logic [5:0] one = 6'd1;
    for (int i = 0; i < 6; i++)
      if (req[order[i]]) return one << order[i];
    return '0;
  endfunction

  // One full transaction from an idle DUT; ends one cycle after the handshake
  task automatic txn(input logic [5:0] req, input logic eret, input logic [31:0] pc,
                     input logic bd, input logic [31:0] epc, input int stall);
    logic        is_exc;
    logic [31:0] target;
    logic [31:0] epc_in;
    is_exc = (req != '0);
    target = is_exc ? EXC_VEC : epc;
    epc_in = bd ? pc - 32'd4 : pc;

    bus.wb_valid = 1'b1; bus.wb_ex_req = req; bus.wb_eret = eret;
    bus.wb_pc = pc; bus.wb_is_bd = bd; bus.cp0_epc = epc;
    bus.redirect_ready = (stall == 0);
    tick();
    wb_noise();
    chk("commit_valid", 32'(bus.cp0_valid), 32'd1);
    chk("commit_ex", 32'(bus.cp0_ex), 32'(m_pick(req)));
    chk("commit_eret", 32'(bus.cp0_eret), 32'(!is_exc && eret));
    chk("commit_flush", 32'(bus.flush), 32'd1);
    chk("commit_stall", 32'(bus.wb_stall), 32'd1);
    if (is_exc) begin
      chk("commit_epc_in", bus.cp0_epc_in, epc_in);
      chk("commit_is_bd", 32'(bus.cp0_is_bd), 32'(bd));
    end
    if (is_exc && m_count != 16'hFFFF) m_count = m_count + 16'd1;
    for (int k = 0; k < int'(FC); k++) begin
      tick();
      wb_noise();
      chk("flush_hi", 32'(bus.flush), 32'd1);
      chk("flush_valid0", 32'(bus.cp0_valid), 32'd0);
      chk("flush_ex0", 32'(bus.cp0_ex | {5'd0, bus.cp0_eret}), 32'd0);
      chk("flush_rv0", 32'(bus.redirect_valid), 32'd0);
      if (k == 0) chk("exc_count", 32'(bus.exc_count), 32'(m_count));
    end
    tick();
    wb_noise();
    chk("redir_valid", 32'(bus.redirect_valid), 32'd1);
    chk("redir_pc", bus.redirect_pc, target);
    chk("redir_flush0", 32'(bus.flush), 32'd0);
    for (int s = 1; s <= stall; s++) begin
      tick();
      wb_noise();
      chk("bp_valid", 32'(bus.redirect_valid), 32'd1);
      chk("bp_pc", bus.redirect_pc, target);
      chk("bp_stall", 32'(bus.wb_stall), 32'd1);
      bus.redirect_ready = (s == stall);
    end
    tick();
    wb_idle();
    bus.redirect_ready = 1'($urandom);
    chk("post_rv0", 32'(bus.redirect_valid), 32'd0);
    chk("post_stall0", 32'(bus.wb_stall), 32'd0);
    chk("post_valid0", 32'(bus.cp0_valid), 32'd0);
    chk("post_count", 32'(bus.exc_count), 32'(m_count));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    wb_idle();
    bus.redirect_ready = 1'b0;
    #12;
    chk("rst_flush", 32'(bus.flush), 32'd0);
    chk("rst_rv", 32'(bus.redirect_valid), 32'd0);
    chk("rst_cp0_valid", 32'(bus.cp0_valid), 32'd0);
    chk("rst_stall", 32'(bus.wb_stall), 32'd0);
    chk("rst_count", 32'(bus.exc_count), 32'd0);
    chk("rst_ex", 32'(bus.cp0_ex), 32'd0);
    @(posedge clock); #1;
    resetn = 1'b1;
    tick();

    // Single Ov, no delay slot
    txn(6'b100000, 1'b0, 32'h80001000, 1'b0, 32'h0, 0);
    // Multi-hot in a delay slot: RI wins
    txn(6'b111110, 1'b0, 32'h80000010, 1'b1, 32'h0, 0);
    // ERET alone, then ERET shadowed by Sys
    txn(6'b000000, 1'b1, 32'h80003000, 1'b0, 32'h80002000, 0);
    txn(6'b000100, 1'b1, 32'h80004000, 1'b0, 32'h80002000, 0);
    // Fetch backpressure for 5 cycles
    txn(6'b001000, 1'b0, 32'h80005000, 1'b0, 32'h0, 5);
    // Delay-slot EPC wraps below zero
    txn(6'b000001, 1'b0, 32'h00000000, 1'b1, 32'h0, 1);

    // Requests without wb_valid must be ignored
    bus.wb_valid = 1'b0; bus.wb_ex_req = 6'h3F; bus.wb_eret = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("novalid_stall", 32'(bus.wb_stall), 32'd0);
      chk("novalid_cp0", 32'(bus.cp0_valid), 32'd0);
    end
    wb_idle();

    for (int i = 0; i < 40; i++) begin
      logic [5:0] req;
      logic       eret;
      req  = ($urandom_range(0, 2) != 0) ? 6'($urandom) : 6'd0;
      eret = 1'($urandom);
      if (req == '0) eret = 1'b1;
      txn(req, eret, $urandom, 1'($urandom), $urandom, int'($urandom_range(0, 3)));
    end

    // Asynchronous reset in the middle of FLUSH
    bus.wb_valid = 1'b1; bus.wb_ex_req = 6'b001000; bus.wb_pc = 32'h80006000;
    tick();
    wb_idle();
    tick();
    chk("mid_flush_hi", 32'(bus.flush), 32'd1);
    #2 resetn = 1'b0;
    #1;
    m_count = '0;
    chk("arst_flush", 32'(bus.flush), 32'd0);
    chk("arst_rv", 32'(bus.redirect_valid), 32'd0);
    chk("arst_cp0_valid", 32'(bus.cp0_valid), 32'd0);
    chk("arst_stall", 32'(bus.wb_stall), 32'd0);
    chk("arst_count", 32'(bus.exc_count), 32'd0);
    @(posedge clock); #1;
    resetn = 1'b1;
    tick();
    chk("arst_idle_stall", 32'(bus.wb_stall), 32'd0);
    chk("arst_idle_valid", 32'(bus.cp0_valid), 32'd0);
    txn(6'b000010, 1'b0, 32'h80007000, 1'b0, 32'h0, 0);

    // Fast-forward the exception counter to just below saturation
    force dut.exc_count_q = 16'hFFFE;
    tick();
    tick();
    release dut.exc_count_q;
    m_count = 16'hFFFE;
    tick();
    chk("ff_count", 32'(bus.exc_count), 32'(m_count));
    txn(6'b100000, 1'b0, 32'h80008000, 1'b0, 32'h0, 0);
    txn(6'b010000, 1'b0, 32'h80009000, 1'b1, 32'h0, 0);
    chk("sat_count", 32'(bus.exc_count), 32'h0000FFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
